// File: rtl/kmeans_centroid_update_if.sv
// Point-in / centroid-out bundle for kmeans_centroid_update.
// master drives points and observes results; slave is the accumulator.
interface kmeans_centroid_update_if;
    logic       IN_VALID;
    logic [7:0] IN_X;
    logic [7:0] IN_Y;
    logic [1:0] IN_LABEL;
    logic       IN_LAST;
    logic       OUT_VALID;
    logic [7:0] OUT_DATA;
    logic       busy;

    modport master (
        output IN_VALID, IN_X, IN_Y, IN_LABEL, IN_LAST,
        input  OUT_VALID, OUT_DATA, busy
    );

    modport slave (
        input  IN_VALID, IN_X, IN_Y, IN_LABEL, IN_LAST,
        output OUT_VALID, OUT_DATA, busy
    );
endinterface

// File: rtl/kmeans_centroid_update.sv
// Accumulates labelled points per cluster, then computes floor-mean centroids with
// one shared 8-step restoring divider and streams x1,y1,x2,y2,x3,y3.
module kmeans_centroid_update #(
    parameter int unsigned NPTS_W = 10
) (
    input  logic                     CLK,
    input  logic                     RESET,
    kmeans_centroid_update_if.slave  bus
);
    localparam int unsigned SUM_W = 8 + NPTS_W;

    typedef enum logic [1:0] {ST_ACCUM, ST_DIV, ST_EMIT} state_t;

    state_t            r_state;
    logic [SUM_W-1:0]  r_sum_x  [0:2];
    logic [SUM_W-1:0]  r_sum_y  [0:2];
    logic [NPTS_W-1:0] r_cnt    [0:2];
    logic [7:0]        r_prev_x [0:2];
    logic [7:0]        r_prev_y [0:2];
    logic [7:0]        r_q      [0:5];
    logic [2:0]        r_slot;
    logic [2:0]        r_bit;
    logic [2:0]        r_emit;
    logic [SUM_W-1:0]  r_rem;
    logic [7:0]        r_quo;
    logic              r_out_valid;
    logic [7:0]        r_out_data;
    logic              r_busy;

    logic [1:0]        w_cl;
    logic [SUM_W-1:0]  w_sum;
    logic [SUM_W-1:0]  w_rem;
    logic [SUM_W-1:0]  w_div;
    logic [NPTS_W-1:0] w_cnt;
    logic [7:0]        w_prev;
    logic [7:0]        w_quo;
    logic              w_ge;

    assign bus.OUT_VALID = r_out_valid;
    assign bus.OUT_DATA  = r_out_data;
    assign bus.busy      = r_busy;

    // Slot s covers cluster s/2, coordinate x (even) or y (odd); bit 7 reloads the sum.
    always_comb begin
        w_cl   = r_slot[2:1];
        w_sum  = r_slot[0] ? r_sum_y[w_cl] : r_sum_x[w_cl];
        w_prev = r_slot[0] ? r_prev_y[w_cl] : r_prev_x[w_cl];
        w_cnt  = r_cnt[w_cl];
        w_rem  = (r_bit == 3'd7) ? w_sum : r_rem;
        w_div  = SUM_W'(w_cnt) << r_bit;
        w_ge   = (w_rem >= w_div);
        w_quo  = (r_bit == 3'd7) ? '0 : r_quo;
        if (w_ge) w_quo[r_bit] = 1'b1;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= ST_ACCUM;
            r_slot      <= '0;
            r_bit       <= 3'd7;
            r_emit      <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
            for (int unsigned k = 0; k < 3; k++) begin
                r_sum_x[k]  <= '0;
                r_sum_y[k]  <= '0;
                r_cnt[k]    <= '0;
                r_prev_x[k] <= '0;
                r_prev_y[k] <= '0;
            end
            for (int unsigned s = 0; s < 6; s++) r_q[s] <= '0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (bus.IN_VALID) begin
                        if (bus.IN_LABEL != 2'd3 && r_cnt[bus.IN_LABEL] != '1) begin
                            r_sum_x[bus.IN_LABEL] <= r_sum_x[bus.IN_LABEL] + SUM_W'(bus.IN_X);
                            r_sum_y[bus.IN_LABEL] <= r_sum_y[bus.IN_LABEL] + SUM_W'(bus.IN_Y);
                            r_cnt[bus.IN_LABEL]   <= r_cnt[bus.IN_LABEL] + 1'b1;
                        end
                        if (bus.IN_LAST) begin
                            r_state <= ST_DIV;
                            r_busy  <= 1'b1;
                            r_slot  <= '0;
                            r_bit   <= 3'd7;
                        end
                    end
                end
                ST_DIV: begin
                    r_rem <= w_ge ? (w_rem - w_div) : w_rem;
                    r_quo <= w_quo;
                    r_bit <= r_bit - 1'b1;
                    if (r_bit == 3'd0) begin
                        r_q[r_slot] <= (w_cnt == '0) ? w_prev : w_quo;
                        if (r_slot == 3'd5) begin
                            // x1 is presented on the last divide edge so emission starts one cycle later.
                            r_state     <= ST_EMIT;
                            r_out_valid <= 1'b1;
                            r_out_data  <= r_q[0];
                            r_prev_x[0] <= r_q[0];
                            r_emit      <= 3'd1;
                        end else begin
                            r_slot <= r_slot + 1'b1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (r_emit != 3'd6) begin
                        r_out_data <= r_q[r_emit];
                        if (r_emit[0]) r_prev_y[r_emit[2:1]] <= r_q[r_emit];
                        else           r_prev_x[r_emit[2:1]] <= r_q[r_emit];
                        r_emit <= r_emit + 1'b1;
                    end else begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_ACCUM;
                        for (int unsigned k = 0; k < 3; k++) begin
                            r_sum_x[k] <= '0;
                            r_sum_y[k] <= '0;
                            r_cnt[k]   <= '0;
                        end
                    end
                end
                default: r_state <= ST_ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_kmeans_centroid_update.sv
// Directed bench for kmeans_centroid_update: frame means, retention, ignored inputs,
// saturation, back-to-back frames and reset aborts.
module tb_kmeans_centroid_update;
    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    kmeans_centroid_update_if bus();

    kmeans_centroid_update #(.NPTS_W(10)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive_point(input logic [7:0] x, input logic [7:0] y,
                               input logic [1:0] lab, input logic last);
        bus.IN_VALID = 1'b1;
        bus.IN_X     = x;
        bus.IN_Y     = y;
        bus.IN_LABEL = lab;
        bus.IN_LAST  = last;
        @(posedge CLK);
    endtask

    task automatic send_point(input logic [7:0] x, input logic [7:0] y,
                              input logic [1:0] lab, input logic last);
        @(negedge CLK);
        drive_point(x, y, lab, last);
    endtask

    // Called right after the edge that accepted the last point; ends in cycle T0+55.
    task automatic frame_out(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3,
                             input logic [7:0] e4, input logic [7:0] e5, input bit noisy);
        logic [7:0] exp [6];
        int         errs;
        logic       exp_v;
        exp  = '{e0, e1, e2, e3, e4, e5};
        errs = 0;
        for (int k = 1; k <= 55; k++) begin
            @(negedge CLK);
            if (k == 1) begin
                bus.IN_VALID = 1'b0;
                bus.IN_LAST  = 1'b0;
            end
            if (noisy && k >= 5 && k <= 9) begin
                bus.IN_VALID = 1'b1;
                bus.IN_X     = 8'd250;
                bus.IN_Y     = 8'd250;
                bus.IN_LABEL = (k % 2 == 1) ? 2'd2 : 2'd0;
                bus.IN_LAST  = (k == 7);
            end
            if (noisy && k == 10) begin
                bus.IN_VALID = 1'b0;
                bus.IN_LAST  = 1'b0;
            end
            exp_v = (k >= 49 && k <= 54);
            if (bus.OUT_VALID !== exp_v) errs++;
            if (exp_v) check({tag, "_data"}, 32'(bus.OUT_DATA), 32'(exp[k-49]));
            if (k == 1 || k == 48 || k == 54) check({tag, "_busy_hi"}, 32'(bus.busy), 32'd1);
            if (k == 55) begin
                check({tag, "_busy_lo"}, 32'(bus.busy), 32'd0);
                check({tag, "_hold"}, 32'(bus.OUT_DATA), 32'(e5));
            end
        end
        check({tag, "_valid_window_errs"}, 32'(errs), 32'd0);
    endtask

    task automatic watch_idle(input string tag, input int n);
        int nv;
        int nb;
        nv = 0;
        nb = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            if (bus.OUT_VALID !== 1'b0) nv++;
            if (bus.busy !== 1'b0) nb++;
        end
        check({tag, "_no_valid"}, 32'(nv), 32'd0);
        check({tag, "_no_busy"}, 32'(nb), 32'd0);
    endtask

    initial begin
        bus.IN_VALID = 1'b0;
        bus.IN_X     = '0;
        bus.IN_Y     = '0;
        bus.IN_LABEL = '0;
        bus.IN_LAST  = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_valid", 32'(bus.OUT_VALID), 32'd0);
        check("rst_data",  32'(bus.OUT_DATA),  32'd0);
        check("rst_busy",  32'(bus.busy),      32'd0);
        RESET = 1'b0;

        // Basic mean, then a point offered in cycle T0+55 starts the next frame.
        send_point(8'd10, 8'd20, 2'd0, 1'b0);
        send_point(8'd20, 8'd40, 2'd0, 1'b0);
        send_point(8'd200, 8'd8, 2'd1, 1'b0);
        send_point(8'd31, 8'd61, 2'd0, 1'b1);
        frame_out("basic", 8'd20, 8'd40, 8'd200, 8'd8, 8'd0, 8'd0, 1'b0);
        drive_point(8'd7, 8'd9, 2'd2, 1'b1);
        frame_out("retain", 8'd20, 8'd40, 8'd200, 8'd8, 8'd7, 8'd9, 1'b0);

        // Label-3 point mid-frame plus traffic while busy, including an IN_LAST.
        send_point(8'd10, 8'd20, 2'd0, 1'b0);
        send_point(8'd255, 8'd255, 2'd3, 1'b0);
        send_point(8'd20, 8'd40, 2'd0, 1'b0);
        send_point(8'd31, 8'd61, 2'd0, 1'b1);
        frame_out("ignored", 8'd20, 8'd40, 8'd200, 8'd8, 8'd7, 8'd9, 1'b1);
        watch_idle("no_requeue", 60);

        // IN_LAST on a dropped label-3 point still closes the frame.
        send_point(8'd40, 8'd60, 2'd2, 1'b0);
        send_point(8'd255, 8'd255, 2'd3, 1'b1);
        frame_out("lab3_last", 8'd20, 8'd40, 8'd200, 8'd8, 8'd40, 8'd60, 1'b0);

        // Saturation of cluster 1.
        for (int i = 0; i < 1100; i++) send_point(8'd255, 8'd255, 2'd1, 1'b0);
        @(negedge CLK);
        check("sat_cnt", 32'(dut.r_cnt[1]), 32'd1023);
        drive_point(8'd0, 8'd0, 2'd1, 1'b1);
        frame_out("sat", 8'd20, 8'd40, 8'd255, 8'd255, 8'd40, 8'd60, 1'b0);

        // Reset during emission.
        send_point(8'd9, 8'd9, 2'd0, 1'b1);
        for (int k = 1; k <= 50; k++) begin
            @(negedge CLK);
            if (k == 1) begin
                bus.IN_VALID = 1'b0;
                bus.IN_LAST  = 1'b0;
            end
        end
        check("pre_rst_valid", 32'(bus.OUT_VALID), 32'd1);
        RESET = 1'b1;
        #1;
        check("emit_rst_valid", 32'(bus.OUT_VALID), 32'd0);
        check("emit_rst_data",  32'(bus.OUT_DATA),  32'd0);
        check("emit_rst_busy",  32'(bus.busy),      32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        send_point(8'd100, 8'd50, 2'd0, 1'b1);
        frame_out("post_rst", 8'd100, 8'd50, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);

        // Reset at T0+20 aborts the frame entirely.
        send_point(8'd5, 8'd5, 2'd0, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (k == 1) begin
                bus.IN_VALID = 1'b0;
                bus.IN_LAST  = 1'b0;
            end
        end
        RESET = 1'b1;
        #1;
        check("div_rst_busy", 32'(bus.busy), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        watch_idle("div_abort", 60);
        send_point(8'd60, 8'd70, 2'd1, 1'b1);
        frame_out("after_abort", 8'd0, 8'd0, 8'd60, 8'd70, 8'd0, 8'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/kmeans_centroid_update.md
# kmeans_centroid_update

Downstream companion to the K-means classifier: receives each classified point (coordinates plus the 2-bit cluster label the classifier produced) and accumulates per-cluster coordinate sums and point counts. On the last point of a frame it computes the three new centroids as floor means using one shared iterative divider. It then streams the six 8-bit centroid coordinates out in the same order the classifier loads them: x1, y1, x2, y2, x3, y3.

## Interface
- `NPTS_W`, default 10: per-cluster point-counter width; max points per cluster is 2^NPTS_W−1.
- `CLK`  in  1  single clock; all state on the rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `IN_VALID`  in  1  point present this cycle.
- `IN_X`  in  8  point x coordinate, unsigned.
- `IN_Y`  in  8  point y coordinate, unsigned.
- `IN_LABEL`  in  2  cluster index: 0, 1 or 2. Value 3 is invalid.
- `IN_LAST`  in  1  qualifies `IN_VALID`; marks the final point of the frame.
- `OUT_VALID`  out  1  one centroid coordinate on `OUT_DATA` this cycle.
- `OUT_DATA`  out  8  centroid coordinate, unsigned.
- `busy`  out  1  high while dividing or emitting; inputs are ignored while high.

## Operation
- Storage per cluster k (0..2):
  - `sum_x[k]` and `sum_y[k]`, each 8+NPTS_W bits.
  - `cnt[k]`, NPTS_W bits.
  - `prev_x[k]` and `prev_y[k]`, each 8 bits.
- Reset value of all storage is 0.
- Point acceptance condition: `IN_VALID`=1 and `busy`=0.
- Update on an accepted point with `IN_LABEL`=k<3 and `cnt[k]` < 2^NPTS_W−1:
  - `sum_x[k]` += `IN_X`, `sum_y[k]` += `IN_Y`, `cnt[k]` += 1.
  - Once `cnt[k]` reaches 2^NPTS_W−1 it saturates. Further points for cluster k are dropped: sums and count stay frozen. Sums therefore never overflow.
- Label 3: the point is dropped. `IN_LAST` on a label-3 point still ends the frame.
- States:
  - ACCUM: default after reset. An accepted point with `IN_LAST`=1 performs its accumulation (if valid) and moves to DIV.
  - DIV: six quotients in order x1, y1, x2, y2, x3, y3. Each is an 8-cycle restoring division, one quotient bit per cycle, MSB first. The remainder starts as the sum; at step b, if remainder ≥ (cnt<<b), subtract and set q[b]. Total 48 cycles, then move to EMIT.
  - EMIT: 6 cycles, one coordinate per cycle in the order above. After the last one: clear all sums and counts, move to ACCUM.
- Quotient is floor(sum/cnt) and always fits in 8 bits.
- If `cnt[k]`=0, the divider is skipped logically for that cluster. Its quotients equal `prev_x[k]`/`prev_y[k]`, but the slot still takes 8 cycles so timing is fixed.
- Every emitted value is written into `prev_*` at emission.
- `prev_*` is retained across frames and cleared only by reset.

## Timing
- Reset values: `OUT_VALID`=0, `OUT_DATA`=0, `busy`=0, state ACCUM.
- Let the last point be accepted at edge T0.
  - `busy` rises after T0.
  - DIV occupies cycles T0+1 .. T0+48.
  - `OUT_VALID`=1 in cycles T0+49 .. T0+54, with `OUT_DATA` = x1, y1, x2, y2, x3, y3.
  - `busy` falls after edge T0+54, so it is low in cycle T0+55.
- First new point is accepted at edge T0+55. Fixed frame-to-output latency is 49 cycles.
- Between emissions `OUT_VALID`=0 and `OUT_DATA` holds its last value.
- `IN_VALID` (with or without `IN_LAST`) while `busy`=1 is ignored entirely and does not queue.
- A frame may contain a single point: `IN_LAST` on the first point is legal.
- `RESET` asserted in any state:
  - Immediately clears everything, including `prev_*`.
  - `OUT_VALID` drops asynchronously.
  - No partial emission resumes.

## Test plan
- **Reset:** assert `RESET` mid-stream. Required: `OUT_VALID`=0, `OUT_DATA`=0, `busy`=0. The next frame {(100,50) label 0, last} outputs 100, 50, 0, 0, 0, 0.
- **Basic mean:**
  - Stimulus: label-0 points (10,20), (20,40), (31,61) with last; label 1 gets (200,8).
  - Required: `OUT_VALID` at T0+49 .. T0+54 with values 20, 40, 200, 8, 0, 0 (floor 61/3=20, 121/3=40).
- **Empty-cluster retention:** after the previous frame, send a frame containing only label 2 (7,9) with last. Required: 20, 40, 200, 8, 7, 9.
- **Ignored inputs:**
  - Label-3 point (255,255) mid-frame contributes nothing.
  - Points driven during `busy`, including one with `IN_LAST`, are not accumulated and start no second frame.
  - The output matches the same frame without them.
- **Saturation:**
  - Stimulus: 1100 points (255,255) label 1, then one last (0,0) label 1.
  - Required: `cnt[1]` stays at 1023 and the output for cluster 1 is 255, 255.
- **Back-to-back frames and reset mid-DIV:**
  - A point offered at T0+55 is accepted.
  - `RESET` asserted at T0+20 aborts the frame: no `OUT_VALID` pulse occurs.
